// File: rtl/multiciclo_control.sv
// Main control FSM for the multicycle MIPS datapath, with retired-fetch counter and illegal flag.
// Define IMM_LOGIC_EN to decode andi/ori/slti; otherwise they are illegal and ExtZero is tied 0.
module multiciclo_control #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Op,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               Branch,
    output logic               IorD,
    output logic               ALUSrcA,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               ExtZero,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic [2:0]         ALUOp,
    output logic [3:0]         State,
    output logic               Illegal,
    output logic [COUNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StImmWb   = 4'd10,
        StJump    = 4'd11,
        StAndiEx  = 4'd12,
        StOriEx   = 4'd13,
        StSltiEx  = 4'd14
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;
`ifdef IMM_LOGIC_EN
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpSlti  = 6'b001010;
`endif

    state_e             state_q, state_d;
    logic [5:0]         op_q;
    logic               illegal_q, illegal_d;
    logic [COUNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Opcode is held so MEMADR can pick lw/sw after the IR input moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            count_q <= '0;
        end else begin
            if (state_q == StDecode) op_q <= Op;
            if (state_q == StFetch && MemReady) count_q <= count_q + COUNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            StFetch:   if (MemReady) state_d = StDecode;
            StDecode: begin
                case (Op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
`ifdef IMM_LOGIC_EN
                    OpAndi:     state_d = StAndiEx;
                    OpOri:      state_d = StOriEx;
                    OpSlti:     state_d = StSltiEx;
`endif
                    default: begin
                        state_d   = StFetch;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr:  state_d = (op_q == OpSw) ? StMemWr : StMemRd;
            StMemRd:   if (MemReady) state_d = StMemWb;
            StMemWr:   if (MemReady) state_d = StFetch;
            StExecute: state_d = StAluWb;
            StAddiEx, StAndiEx, StOriEx, StSltiEx: state_d = StImmWb;
            default:   state_d = StFetch;
        endcase
    end

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        Branch   = 1'b0;
        IorD     = 1'b0;
        ALUSrcA  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ExtZero  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        ALUOp    = 3'b000;
        case (state_q)
            StFetch: begin
                // Gated by rst_n so a held reset never writes PC/IR.
                PCWrite = MemReady & rst_n;
                IRWrite = MemReady & rst_n;
                ALUSrcB = 2'b01;
            end
            StDecode:  ALUSrcB = 2'b11;
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StMemRd:   IorD = 1'b1;
            StMemWb: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            StMemWr: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            StExecute: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
            end
            StAluWb: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            StBranch: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b001;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
            end
            StAddiEx, StSltiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (state_q == StSltiEx) ? 3'b111 : 3'b000;
            end
            StAndiEx, StOriEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (state_q == StAndiEx) ? 3'b100 : 3'b110;
`ifdef IMM_LOGIC_EN
                ExtZero = 1'b1;
`endif
            end
            StImmWb:   RegWrite = 1'b1;
            StJump: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign State      = state_q;
    assign Illegal    = illegal_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_multiciclo_control.sv
// Bench for multiciclo_control: instruction-level path model, directed sequences, random stimulus.
// A second instance with a 4-bit counter exercises counter wrap-around.
`timescale 1ns/1ps
module tb_multiciclo_control;

    typedef struct packed {
        logic       pcwrite, irwrite, memwrite, regwrite, branch;
        logic       iord, alusrca, regdst, memtoreg, extzero;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] aluop;
    } outs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] Op = 6'd0;
    logic MemReady = 1'b1;
    always #5 clk = ~clk;

    logic d_pcw, d_irw, d_memw, d_regw, d_br, d_iord, d_srca, d_rdst, d_m2r, d_ext, d_ill;
    logic [1:0] d_srcb, d_pcsrc;
    logic [2:0] d_aluop;
    logic [3:0] d_state;
    logic [15:0] d_count;
    logic s_pcw, s_irw, s_memw, s_regw, s_br, s_iord, s_srca, s_rdst, s_m2r, s_ext, s_ill;
    logic [1:0] s_srcb, s_pcsrc;
    logic [2:0] s_aluop;
    logic [3:0] s_state;
    logic [3:0] s_count;

    multiciclo_control dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady),
        .PCWrite(d_pcw), .IRWrite(d_irw), .MemWrite(d_memw), .RegWrite(d_regw), .Branch(d_br),
        .IorD(d_iord), .ALUSrcA(d_srca), .RegDst(d_rdst), .MemtoReg(d_m2r), .ExtZero(d_ext),
        .ALUSrcB(d_srcb), .PCSrc(d_pcsrc), .ALUOp(d_aluop), .State(d_state),
        .Illegal(d_ill), .InstrCount(d_count)
    );

    multiciclo_control #(.COUNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady),
        .PCWrite(s_pcw), .IRWrite(s_irw), .MemWrite(s_memw), .RegWrite(s_regw), .Branch(s_br),
        .IorD(s_iord), .ALUSrcA(s_srca), .RegDst(s_rdst), .MemtoReg(s_m2r), .ExtZero(s_ext),
        .ALUSrcB(s_srcb), .PCSrc(s_pcsrc), .ALUOp(s_aluop), .State(s_state),
        .Illegal(s_ill), .InstrCount(s_count)
    );

    outs_t d_o, s_o;
    assign d_o = {d_pcw, d_irw, d_memw, d_regw, d_br, d_iord, d_srca, d_rdst, d_m2r, d_ext,
                  d_srcb, d_pcsrc, d_aluop};
    assign s_o = {s_pcw, s_irw, s_memw, s_regw, s_br, s_iord, s_srca, s_rdst, s_m2r, s_ext,
                  s_srcb, s_pcsrc, s_aluop};

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Remaining states after DECODE, low nibble first; FETCH (0) terminates. 0 means illegal.
    function automatic int route(input logic [5:0] op);
        case (op)
            6'b100011: return 'h432;
            6'b101011: return 'h52;
            6'b000000: return 'h76;
            6'b000100: return 'h8;
            6'b001000: return 'hA9;
            6'b000010: return 'hB;
`ifdef IMM_LOGIC_EN
            6'b001100: return 'hAC;
            6'b001101: return 'hAD;
            6'b001010: return 'hAE;
`endif
            default:   return 0;
        endcase
    endfunction

    function automatic outs_t exp_out(input int st, input logic mr, input logic rn);
        outs_t o;
        o = '0;
        case (st)
            0:  begin o.alusrcb = 2'b01; o.pcwrite = mr & rn; o.irwrite = mr & rn; end
            1:  o.alusrcb = 2'b11;
            2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            3:  o.iord = 1'b1;
            4:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
            5:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
            6:  begin o.alusrca = 1'b1; o.aluop = 3'b010; end
            7:  begin o.regdst = 1'b1; o.regwrite = 1'b1; end
            8:  begin o.alusrca = 1'b1; o.aluop = 3'b001; o.pcsrc = 2'b01; o.branch = 1'b1; end
            9, 12, 13, 14: begin
                o.alusrca = 1'b1;
                o.alusrcb = 2'b10;
                o.aluop = (st == 12) ? 3'b100 : (st == 13) ? 3'b110 : (st == 14) ? 3'b111 : 3'b000;
`ifdef IMM_LOGIC_EN
                o.extzero = (st == 12 || st == 13);
`endif
            end
            10: o.regwrite = 1'b1;
            11: begin o.pcsrc = 2'b10; o.pcwrite = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    int m_state = 0;
    int m_path = 0;
    int unsigned m_count = 0;
    logic m_illegal = 1'b0;
    int m_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_path = 0; m_count = 0; m_illegal = 1'b0;
        end else begin
            m_illegal = 1'b0;
            if (m_state == 0) begin
                if (MemReady) begin m_count++; m_state = 1; end
            end else if (m_state == 1) begin
                m_r = route(Op);
                if (m_r == 0) begin m_illegal = 1'b1; m_state = 0; end
                else begin m_state = m_r & 15; m_path = m_r >> 4; end
            end else if (!((m_state == 3 || m_state == 5) && !MemReady)) begin
                m_state = m_path & 15;
                m_path = m_path >> 4;
            end
        end
    end

    outs_t e_o;
    always @(negedge clk) begin
        e_o = exp_out(m_state, MemReady, rst_n);
        check("state", 32'(d_state), 32'(m_state));
        check("outputs", 32'(d_o), 32'(e_o));
        check("illegal", 32'(d_ill), 32'(m_illegal));
        check("count", 32'(d_count), m_count & 32'hFFFF);
        check("small_state", 32'(s_state), 32'(m_state));
        check("small_outputs", 32'(s_o), 32'(e_o));
        check("small_illegal", 32'(s_ill), 32'(m_illegal));
        check("small_count", 32'(s_count), m_count & 32'hF);
    end

    // Walk n cycles: drive MemReady per cycle, check State, advance except after the last entry.
    task automatic run_seq(input logic [5:0] op, input int n, input logic [31:0] mrs,
                           input logic [63:0] sts);
        Op = op;
        for (int i = 0; i < n; i++) begin
            MemReady = mrs[i];
            check("seq_state", 32'(d_state), 32'(sts[4*i +: 4]));
            if (i < n - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    logic [5:0] ops [10] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h0C, 6'h0D, 6'h0A, 6'h3F};
    logic [31:0] rnd;

    initial begin
        #2;
        check("rst_state", 32'(d_state), 0);
        check("rst_pcwrite", 32'(d_pcw), 0);
        check("rst_irwrite", 32'(d_irw), 0);
        check("rst_alusrcb", 32'(d_srcb), 1);
        check("rst_count", 32'(d_count), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        run_seq(6'h00, 3, 'b111, 'h610);
        check("r_aluop", 32'(d_aluop), 2);
        run_seq(6'h00, 2, 'b11, 'h76);
        check("r_regwrite", 32'(d_regw), 1);
        run_seq(6'h00, 2, 'b11, 'h07);
        check("r_count", 32'(d_count), 1);

        run_seq(6'h23, 8, 'b11100111, 'h04333210);

        Op = 6'h2B;
        MemReady = 1'b0;
        #1 check("sw_irwrite_wait", 32'(d_irw), 0);
        @(posedge clk);
        #1 MemReady = 1'b1;
        #1 check("sw_irwrite_go", 32'(d_irw), 1);
        run_seq(6'h2B, 6, 'b110111, 'h055210);

        run_seq(6'h04, 3, 'b111, 'h810);
        check("beq_aluop", 32'(d_aluop), 1);
        check("beq_pcsrc", 32'(d_pcsrc), 1);
        check("beq_branch", 32'(d_br), 1);
        run_seq(6'h04, 2, 'b11, 'h08);

        run_seq(6'h02, 3, 'b111, 'hB10);
        check("j_pcsrc", 32'(d_pcsrc), 2);
        check("j_pcwrite", 32'(d_pcw), 1);
        run_seq(6'h02, 2, 'b11, 'h0B);

        run_seq(6'h3F, 3, 'b111, 'h010);
        check("illegal_flag", 32'(d_ill), 1);

`ifdef IMM_LOGIC_EN
        run_seq(6'h0C, 3, 'b111, 'hC10);
        check("andi_aluop", 32'(d_aluop), 4);
        check("andi_extzero", 32'(d_ext), 1);
        run_seq(6'h0C, 3, 'b111, 'h0AC);
`else
        run_seq(6'h0C, 3, 'b111, 'h010);
        check("andi_illegal", 32'(d_ill), 1);
`endif

        // Reset in the middle of a stalled store.
        run_seq(6'h2B, 4, 'b0111, 'h5210);
        MemReady = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_state", 32'(d_state), 0);
        check("midrst_memwrite", 32'(d_memw), 0);
        check("midrst_pcwrite", 32'(d_pcw), 0);
        check("midrst_count", 32'(d_count), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        run_seq(6'h08, 5, 'b11111, 'h0A910);

        // 16 fetches: 4-bit counter wraps to 0.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        Op = 6'h3F;
        MemReady = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        check("wrap_small", 32'(s_count), 0);
        check("wrap_big", 32'(d_count), 16);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rnd = $urandom;
            Op = (rnd[3:0] < 4'd10) ? ops[rnd[3:0]] : rnd[9:4];
            MemReady = (rnd[12:11] != 2'b00);
            if (rnd[31:24] == 8'd0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiciclo_control.md
# multiciclo_control

Main control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback steps, drives datapath enables and muxes, and issues the 3-bit ALUOp consumed by the ALU control decoder. Memory steps stall on a ready handshake. The block also keeps a retired-fetch counter and flags illegal opcodes.

## Interface
- `COUNT_W`, 16, width of `InstrCount`
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `Op` in 6: opcode from the instruction register, sampled in DECODE
- `MemReady` in 1: memory access completes this cycle
- `PCWrite`, `IRWrite`, `MemWrite`, `RegWrite`, `Branch` out 1: enables
- `IorD`, `ALUSrcA`, `RegDst`, `MemtoReg`, `ExtZero` out 1: mux selects; `ExtZero`=1 selects zero-extended immediate
- `ALUSrcB` out 2, `PCSrc` out 2: mux selects
- `ALUOp` out 3: 000 add, 001 sub, 010 use Funct, 100 and, 110 or, 111 slt
- `State` out 4: current state code
- `Illegal` out 1: registered one-cycle flag
- `InstrCount` out `COUNT_W`: count of completed fetches

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, IMMWB 10, JUMP 11, ANDIEX 12, ORIEX 13, SLTIEX 14. Code 15 is unused and goes to FETCH.
- Outputs are decoded from state only, except `PCWrite`/`IRWrite` in FETCH, which are gated by `MemReady`. Every output not listed for a state is 0.
- FETCH: `ALUSrcB`=01, `ALUOp`=000, `IRWrite`=`PCWrite`=`MemReady`. Stays in FETCH until `MemReady`, then goes to DECODE.
- DECODE: `ALUSrcB`=11, `ALUOp`=000. Next state by `Op`:
  - 100011/101011 → MEMADR
  - 000000 → EXECUTE
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - 001100 → ANDIEX, 001101 → ORIEX, 001010 → SLTIEX, only when `IMM_LOGIC_EN` is defined
  - any other opcode → FETCH and sets `Illegal`
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=000. Goes to MEMRD for lw, MEMWR for sw. Uses the `Op` value held from DECODE.
- MEMRD: `IorD`=1. Holds until `MemReady`, then goes to MEMWB.
- MEMWB: `MemtoReg`=1, `RegWrite`=1, then FETCH.
- MEMWR: `IorD`=1, `MemWrite`=1. `MemWrite` stays high while waiting. Goes to FETCH on `MemReady`.
- EXECUTE: `ALUSrcA`=1, `ALUOp`=010, then ALUWB.
- ALUWB: `RegDst`=1, `RegWrite`=1, then FETCH.
- BRANCH: `ALUSrcA`=1, `ALUOp`=001, `PCSrc`=01, `Branch`=1, then FETCH.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=000, then IMMWB.
- ANDIEX and ORIEX: as ADDIEX, but `ALUOp`=100 or 110 respectively and `ExtZero`=1.
- SLTIEX: as ADDIEX, but `ALUOp`=111.
- IMMWB: `RegWrite`=1 (`RegDst`=0, `MemtoReg`=0), then FETCH.
- JUMP: `PCSrc`=10, `PCWrite`=1, then FETCH.
- `InstrCount` increments on every clock edge where state=FETCH and `MemReady`=1. It wraps from all-ones to 0.
- `Illegal` is registered. It is 1 for exactly the cycle after a DECODE with an unknown opcode, otherwise 0.

## Timing
- Cycle counts with zero memory wait (includes FETCH):
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, andi/ori/slti 4.
  - Each cycle `MemReady` is low in FETCH, MEMRD or MEMWR adds one cycle.
- Reset (`rst_n`=0, takes effect asynchronously):
  - State becomes FETCH, `InstrCount`=0, `Illegal`=0.
  - While reset is held, `PCWrite`=`IRWrite`=0 regardless of `MemReady`.
  - All other outputs take their FETCH values: `ALUSrcB`=01, `ALUOp`=000, everything else 0.
- Reset asserted mid-instruction abandons that instruction. The first edge after release evaluates FETCH.
- `MemReady` is ignored in states other than FETCH, MEMRD and MEMWR.

## Configuration
- `IMM_LOGIC_EN` defined: andi, ori and slti are decoded into ANDIEX, ORIEX and SLTIEX.
- `IMM_LOGIC_EN` undefined: those three opcodes are illegal and states 12–14 are not reachable. `ExtZero` is tied to 0.

## Test plan
- Reset, then `Op`=000000 with `MemReady` held 1 → `State` sequence 0,1,6,7,0; `ALUOp`=010 in EXECUTE; `RegWrite`=1 only in ALUWB; `InstrCount`=1.
- lw (100011) with `MemReady` low for 2 cycles in MEMRD → `State` sequence 0,1,2,3,3,3,4,0; total 7 cycles.
- sw (101011), `MemReady`=0 during FETCH for 1 cycle → `IRWrite`=0 then 1; `MemWrite`=1 throughout MEMWR; no `RegWrite`.
- beq (000100) → `ALUOp`=001, `PCSrc`=01, `Branch`=1 in state 8. j (000010) → `PCSrc`=10, `PCWrite`=1 in state 11.
- `Op`=111111 → DECODE goes to FETCH and `Illegal`=1 for one cycle. With the macro undefined, `Op`=001100 also sets `Illegal`; with it defined, it goes to state 12 with `ALUOp`=100 and `ExtZero`=1.
- Assert `rst_n` low during MEMWR → `State`=0 and `MemWrite`=0 immediately, `InstrCount`=0. Separately, preload `InstrCount` to 0xFFFF and run one fetch → it wraps to 0.
